// File: rtl/data_mem_sequencer_if.sv
// Request/response bus between the MEM stage, the data memory macro and the sequencer.
// DATA_MEM_SEQ_ERR_EN adds the sticky 'err' flag to the bus.
interface data_mem_sequencer_if;
  logic        en;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] mem_rdata;
  logic        mem_cs;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] rdata;
  logic        done;
  logic        data_mem_access;
`ifdef DATA_MEM_SEQ_ERR_EN
  logic        err;

  modport slave (
    input  en, mem_re, mem_we, addr, wdata, mem_rdata,
    output mem_cs, mem_wr, mem_addr, mem_wdata, rdata, done, data_mem_access, err
  );
  modport master (
    output en, mem_re, mem_we, addr, wdata, mem_rdata,
    input  mem_cs, mem_wr, mem_addr, mem_wdata, rdata, done, data_mem_access, err
  );
`else
  modport slave (
    input  en, mem_re, mem_we, addr, wdata, mem_rdata,
    output mem_cs, mem_wr, mem_addr, mem_wdata, rdata, done, data_mem_access
  );
  modport master (
    output en, mem_re, mem_we, addr, wdata, mem_rdata,
    input  mem_cs, mem_wr, mem_addr, mem_wdata, rdata, done, data_mem_access
  );
`endif
endinterface

// File: rtl/data_mem_sequencer.sv
// Fixed-latency data memory access sequencer (IDLE -> ACCESS -> HOLD) for the MEM stage.
// Optional DATA_MEM_SEQ_ERR_EN: sticky err flag on simultaneous load/store requests.
module data_mem_sequencer #(
  parameter int unsigned LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        req_q;
  logic [15:0] rdata_q;
  logic        accept;
  logic        capture;
  logic        req_any;

  assign req_any = bus.mem_re | bus.mem_we;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && req_any) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // en is deliberately ignored until the access has finished
        if (cnt == 4'd0) begin
          capture   = ~req_q.wr;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (bus.en) begin
          if (req_any) begin
            accept    = 1'b1;
            cnt_nxt   = CNT_INIT;
            state_nxt = ACCESS;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      rdata_q <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // simultaneous re/we resolves to a store
      if (accept)  req_q   <= '{wr: bus.mem_we, addr: bus.addr, wdata: bus.wdata};
      if (capture) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_cs          = (state == ACCESS);
  assign bus.mem_wr          = (state == ACCESS) & req_q.wr;
  assign bus.mem_addr        = req_q.addr;
  assign bus.mem_wdata       = req_q.wdata;
  assign bus.rdata           = rdata_q;
  assign bus.done            = (state == HOLD);
  assign bus.data_mem_access = (state != IDLE);

`ifdef DATA_MEM_SEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    err_q <= 1'b0;
    else if (accept && bus.mem_re && bus.mem_we) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`endif

endmodule

// File: doc/data_mem_sequencer.md
# data_mem_sequencer

Memory-side counterpart to the pipeline enable generator: accepts a load/store request from the MEM stage on an enable pulse, sequences a fixed-latency access to the 16-bit data memory, and reports back via `data_mem_access` so the enable generator can stall the pipeline. It sits between the MEM-stage control signals and the data memory macro and returns captured read data to the write-back path.

## Interface
- `LATENCY`, 3: memory access cycles per request; legal range 1..15.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  pipeline advance pulse from the enable generator; one cycle wide.
- `mem_re`  in  1  MEM-stage load request.
- `mem_we`  in  1  MEM-stage store request.
- `addr`  in  16  word address.
- `wdata`  in  16  store data.
- `mem_rdata`  in  16  read data from the memory macro.
- `mem_cs`  out  1  memory chip select.
- `mem_wr`  out  1  memory write strobe; valid only while `mem_cs`=1.
- `mem_addr`  out  16  latched address.
- `mem_wdata`  out  16  latched store data.
- `rdata`  out  16  captured load data.
- `done`  out  1  access complete, result held.
- `data_mem_access`  out  1  access in progress; to the enable generator.

## Operation
- FSM states: IDLE, ACCESS, HOLD. `rst` forces IDLE, 4-bit down counter `cnt`=0, all outputs 0, `rdata`=0.
- IDLE: on an edge with `en`=1 and (`mem_re` | `mem_we`), latch `addr`, `wdata`, and `wr` = `mem_we`; load `cnt`=LATENCY-1; go to ACCESS. With `en`=0 or no request, stay in IDLE.
- `mem_re`=1 and `mem_we`=1 together: the request is treated as a store.
- ACCESS: `mem_cs`=1, `mem_wr`=latched `wr`, and `mem_addr`/`mem_wdata` come from the latches. `cnt` decrements each edge. On the edge where `cnt`=0, capture `mem_rdata` into `rdata` (loads only; `rdata` is unchanged on stores) and go to HOLD. `en` is ignored in ACCESS.
- HOLD: `done`=1 and `rdata` is stable.
  - On `en`=1 with no request: go to IDLE.
  - On `en`=1 with a new request: latch it and go directly to ACCESS (back-to-back).
  - With `en`=0: stay in HOLD.
- `data_mem_access` = (state ≠ IDLE). It is a combinational decode of the state register.
- `mem_addr`/`mem_wdata` hold their last latched values outside ACCESS. They are 0 after reset.

## Timing
- `mem_cs` is high for exactly LATENCY consecutive cycles per request, starting the cycle after acceptance.
- Acceptance-to-`done` latency is LATENCY+1 edges. `done` rises in the cycle after the last `mem_cs` cycle.
- `mem_rdata` must be valid in the final `mem_cs` cycle. It is sampled on the edge that ends that cycle.
- `data_mem_access` rises in the cycle after the accepting edge. It falls in the cycle after the HOLD→IDLE edge.
- Back-to-back requests: `done` drops and `mem_cs` rises in the same cycle. There are no idle cycles between requests.
- Reset asserted mid-ACCESS: `mem_cs`, `done`, and `data_mem_access` drop immediately (no clock edge needed), and the access is discarded.

## Configuration
- `DATA_MEM_SEQ_ERR_EN` defined: adds output `err` (1 bit, reset 0).
  - `err` is sticky. It is set on an accepting edge where `mem_re` and `mem_we` are both 1, and is cleared only by `rst`.
  - The request still executes as a store.
- Not defined: no `err` port. Simultaneous read/write silently becomes a store.

## Test plan
- Reset, then load with LATENCY=3: `en`=1, `mem_re`=1, `addr`=0x0040, `mem_rdata`=0xBEEF. Required response: `mem_cs` high for 3 cycles with `mem_wr`=0 and `mem_addr`=0x0040, then `done`=1 and `rdata`=0xBEEF. `data_mem_access` is high from cycle 1 through HOLD.
- Store: `en`=1, `mem_we`=1, `addr`=0x0012, `wdata`=0x1234. Required response: 3 cycles with `mem_cs`=1, `mem_wr`=1, `mem_wdata`=0x1234; `rdata` keeps its prior value; `done` is then asserted.
- HOLD then back-to-back: `en` low for 5 cycles in HOLD, then `en`=1 with a load to 0x0041. Required response: `done` stays 1 for those 5 cycles, then ACCESS begins the next cycle with no IDLE gap.
- `en` pulses during ACCESS and `en` with no request in IDLE: no state change, `mem_cs` count stays 3.
- Async reset during the 2nd ACCESS cycle: `mem_cs`, `done`, and `data_mem_access` go to 0 before the next edge; the FSM is in IDLE and `rdata`=0.
- With `DATA_MEM_SEQ_ERR_EN`: `mem_re`=`mem_we`=1 on acceptance. Required response: `err`=1 from the next cycle and it persists through a following clean load; a store is performed; `rst` clears `err`.
